gray_count_ctrl: RTL and testbench

Command-driven sequencer around a WIDTH-bit Gray-code counter. It starts, stops, pauses and resumes the count and runs it up to a programmed terminal value, either once or periodically. It reports the Gray and binary counts, completion pulses and a completed-period tally. It sits between a control/CSR front end and any logic that consumes the Gray count.

---
 rtl/gray_count_ctrl.sv | 172 +++++++++++++++++
 tb/tb_gray_count_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_count_ctrl.sv
// gray_count_ctrl
// Command-driven sequencer around a binary counter whose value is also
// published in Gray code. START/STOP/PAUSE/RESUME steer an IDLE/RUN/PAUSE
// state machine. The counter runs from 0 up to a latched terminal value,
// either once (one-shot) or repeatedly (periodic). A saturating tally counts
// the completion pulses seen since the last START.

module gray_count_ctrl #(
  parameter int WIDTH   = 4,
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_target,
  input  logic               cmd_periodic,
  output logic [WIDTH-1:0]   gray_count,
  output logic [WIDTH-1:0]   bin_count,
  output logic               busy,
  output logic               paused,
  output logic               done,
  output logic               err,
  output logic [TALLY_W-1:0] tally
);

  // Command opcodes as carried on cmd_op.
  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_PAUSE  = 2'b10;
  localparam logic [1:0] OP_RESUME = 2'b11;

  localparam logic [WIDTH-1:0]   BIN_ZERO   = '0;
  localparam logic [WIDTH-1:0]   BIN_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TALLY_W-1:0] TALLY_ZERO = '0;
  localparam logic [TALLY_W-1:0] TALLY_ONE  = {{(TALLY_W-1){1'b0}}, 1'b1};
  localparam logic [TALLY_W-1:0] TALLY_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  // Architectural state.
  state_t             state_q,    state_d;
  logic [WIDTH-1:0]   bin_q,      bin_d;
  logic [WIDTH-1:0]   target_q,   target_d;
  logic               periodic_q, periodic_d;
  logic               done_q,     done_d;
  logic               err_q,      err_d;
  logic [TALLY_W-1:0] tally_q,    tally_d;

  // Command decode results.
  logic cmd_accept;
  logic cmd_reject;

  // Counter status helpers.
  logic               terminal_hit;
  logic [WIDTH-1:0]   bin_inc;
  logic [TALLY_W-1:0] tally_inc;

  // A command is accepted only in the state where it makes sense; anything
  // else is flagged through err and otherwise ignored, so a running count
  // keeps advancing underneath a rejected command.
  always_comb begin
    cmd_accept = 1'b0;
    cmd_reject = 1'b0;
    if (cmd_valid) begin
      unique case (cmd_op)
        OP_START:  cmd_accept = (state_q == S_IDLE);
        OP_STOP:   cmd_accept = (state_q == S_RUN) || (state_q == S_PAUSE);
        OP_PAUSE:  cmd_accept = (state_q == S_RUN);
        OP_RESUME: cmd_accept = (state_q == S_PAUSE);
        default:   cmd_accept = 1'b0;
      endcase
      cmd_reject = !cmd_accept;
    end
  end

  assign terminal_hit = (bin_q == target_q);
  assign bin_inc      = bin_q + BIN_ONE;
  assign tally_inc    = (tally_q == TALLY_MAX) ? tally_q : (tally_q + TALLY_ONE);

  // Next-state logic: an accepted command takes priority over the terminal
  // action, so STOP or PAUSE on the terminal edge produce no completion.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    target_d   = target_q;
    periodic_d = periodic_q;
    tally_d    = tally_q;
    done_d     = 1'b0;
    err_d      = cmd_reject;

    if (cmd_accept) begin
      unique case (cmd_op)
        OP_START: begin
          target_d   = cmd_target;
          periodic_d = cmd_periodic;
          bin_d      = BIN_ZERO;
          tally_d    = TALLY_ZERO;
          state_d    = S_RUN;
        end
        OP_STOP: begin
          bin_d   = BIN_ZERO;
          state_d = S_IDLE;
        end
        OP_PAUSE: begin
          state_d = S_PAUSE;
        end
        OP_RESUME: begin
          state_d = S_RUN;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end else if (state_q == S_RUN) begin
      if (terminal_hit) begin
        // Completion: wrap for periodic runs, park at the target otherwise.
        done_d  = 1'b1;
        tally_d = tally_inc;
        if (periodic_q) begin
          bin_d = BIN_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end else begin
        bin_d = bin_inc;
      end
    end
  end

  // State register; reset overrides any command presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bin_q      <= BIN_ZERO;
      target_q   <= BIN_ZERO;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tally_q    <= TALLY_ZERO;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      target_q   <= target_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tally_q    <= tally_d;
    end
  end

  // Gray encoding of the registered count: each bit is the XOR of a binary
  // bit and its upper neighbour, the MSB passes straight through.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_gray
      assign gray_count[gi] = bin_q[gi] ^ bin_q[gi+1];
    end
  endgenerate
  assign gray_count[WIDTH-1] = bin_q[WIDTH-1];

  assign bin_count = bin_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign paused    = (state_q == S_PAUSE);
  assign done      = done_q;
  assign err       = err_q;
  assign tally     = tally_q;

endmodule

// File: tb/tb_gray_count_ctrl.sv
// Self-checking bench for gray_count_ctrl: directed scenarios checked against
// hand-derived constants plus a randomized phase checked against a
// transaction-level reference model.

module tb_gray_count_ctrl;

  localparam logic [1:0] OP_START  = 2'b00;
  localparam logic [1:0] OP_STOP   = 2'b01;
  localparam logic [1:0] OP_PAUSE  = 2'b10;
  localparam logic [1:0] OP_RESUME = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_target = 4'd0;
  logic       cmd_periodic = 1'b0;
  logic [3:0] gray_count;
  logic [3:0] bin_count;
  logic       busy;
  logic       paused;
  logic       done;
  logic       err;
  logic [7:0] tally;

  int n_checks = 0;
  int n_fail   = 0;

  // Gray table built by the reflect-and-prefix construction.
  logic [3:0] gray_tab [16];

  // Reference model state.
  bit         m_busy;
  bit         m_paused;
  logic [3:0] m_bin;
  logic [3:0] m_T;
  bit         m_per;
  int         m_tally;
  bit         m_done;
  bit         m_err;

  gray_count_ctrl #(.WIDTH(4), .TALLY_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_target   (cmd_target),
    .cmd_periodic (cmd_periodic),
    .gray_count   (gray_count),
    .bin_count    (bin_count),
    .busy         (busy),
    .paused       (paused),
    .done         (done),
    .err          (err),
    .tally        (tally)
  );

  always #5 clk = ~clk;

  task automatic build_gray_table();
    gray_tab[0] = 4'd0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < (1 << k); i++) begin
        gray_tab[(1 << k) + i] = 4'((1 << k) | gray_tab[(1 << k) - 1 - i]);
      end
    end
  endtask

  // One clock edge of the reference model, written from the command rules.
  task automatic model_edge(input bit r, input bit v, input logic [1:0] op,
                            input logic [3:0] t, input bit p);
    bit acc;
    if (r) begin
      m_busy = 0; m_paused = 0; m_bin = 0; m_T = 0; m_per = 0;
      m_tally = 0; m_done = 0; m_err = 0;
      return;
    end
    m_done = 0;
    m_err  = 0;
    acc    = 0;
    if (v) begin
      case (op)
        OP_START:  acc = !m_busy;
        OP_STOP:   acc = m_busy;
        OP_PAUSE:  acc = m_busy && !m_paused;
        default:   acc = m_paused;
      endcase
      m_err = !acc;
    end
    if (acc) begin
      case (op)
        OP_START: begin
          m_T = t; m_per = p; m_bin = 0; m_tally = 0; m_busy = 1; m_paused = 0;
        end
        OP_STOP:  begin m_bin = 0; m_busy = 0; m_paused = 0; end
        OP_PAUSE: m_paused = 1;
        default:  m_paused = 0;
      endcase
    end else if (m_busy && !m_paused) begin
      if (m_bin == m_T) begin
        m_done = 1;
        if (m_tally < 255) m_tally = m_tally + 1;
        if (m_per) m_bin = 0;
        else       m_busy = 0;
      end else begin
        m_bin = m_bin + 4'd1;
      end
    end
  endtask

  // Present inputs for one edge, advance the model, then settle past the edge.
  task automatic drive(input bit r, input bit v, input logic [1:0] op,
                       input logic [3:0] t, input bit p);
    rst = r; cmd_valid = v; cmd_op = op; cmd_target = t; cmd_periodic = p;
    if (r || v)
      $display("txn t=%0t rst=%0b valid=%0b op=%0d target=%0d periodic=%0b",
               $time, r, v, op, t, p);
    @(posedge clk);
    model_edge(r, v, op, t, p);
    #1;
    rst = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic idle();
    drive(0, 0, OP_START, 4'd0, 0);
  endtask

  task automatic test_reset();
    drive(1, 1, OP_START, 4'd5, 1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (paused !== 1'b0) begin n_fail++; $display("FAIL reset_paused got %b want 0", paused); end
    n_checks++; if (bin_count !== 4'd0) begin n_fail++; $display("FAIL reset_bin got %h want 0", bin_count); end
    n_checks++; if (gray_count !== 4'd0) begin n_fail++; $display("FAIL reset_gray got %h want 0", gray_count); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got done=%b err=%b want 0/0", done, err); end
    n_checks++; if (tally !== 8'd0) begin n_fail++; $display("FAIL reset_tally got %0d want 0", tally); end
    idle();
    n_checks++; if (busy !== 1'b0 || gray_count !== 4'd0) begin n_fail++; $display("FAIL reset_idle got busy=%b gray=%h want 0/0", busy, gray_count); end
  endtask

  task automatic test_oneshot();
    drive(0, 1, OP_START, 4'd5, 0);
    for (int n = 0; n <= 5; n++) begin
      n_checks++;
      if (gray_count !== gray_tab[n] || bin_count !== 4'(n) || done !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL oneshot_step%0d got gray=%h bin=%0d done=%b busy=%b want gray=%h bin=%0d done=0 busy=1",
                 n, gray_count, bin_count, done, busy, gray_tab[n], n);
      end
      idle();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bin_count !== 4'd5 || tally !== 8'd1) begin
      n_fail++;
      $display("FAIL oneshot_done got done=%b busy=%b bin=%0d tally=%0d want 1/0/5/1", done, busy, bin_count, tally);
    end
    idle();
    n_checks++;
    if (done !== 1'b0 || bin_count !== 4'd5 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_hold got done=%b bin=%0d busy=%b want 0/5/0", done, bin_count, busy);
    end
  endtask

  task automatic test_periodic();
    logic [3:0] prev;
    drive(0, 1, OP_START, 4'd3, 1);
    for (int i = 0; i <= 12; i++) begin
      n_checks++;
      if (gray_count !== gray_tab[i % 4] || done !== ((i > 0) && (i % 4 == 0)) || tally !== 8'(i / 4)) begin
        n_fail++;
        $display("FAIL periodic3_cyc%0d got gray=%h done=%b tally=%0d want gray=%h done=%b tally=%0d",
                 i, gray_count, done, tally, gray_tab[i % 4], (i > 0) && (i % 4 == 0), i / 4);
      end
      if (i < 12) idle();
    end
    drive(0, 1, OP_STOP, 4'd0, 0);
    drive(0, 1, OP_START, 4'd15, 1);
    prev = gray_count;
    for (int i = 1; i <= 16; i++) begin
      idle();
      n_checks++;
      if (gray_count !== gray_tab[i % 16] || $countones(gray_count ^ prev) != 1 || done !== (i == 16)) begin
        n_fail++;
        $display("FAIL periodic15_cyc%0d got gray=%h prev=%h done=%b want gray=%h one-bit-step done=%b",
                 i, gray_count, prev, done, gray_tab[i % 16], i == 16);
      end
      prev = gray_count;
    end
    drive(0, 1, OP_STOP, 4'd0, 0);
  endtask

  task automatic test_pause();
    int edges;
    drive(0, 1, OP_START, 4'd7, 0);
    repeat (3) idle();
    drive(0, 1, OP_PAUSE, 4'd0, 0);
    n_checks++;
    if (paused !== 1'b1 || bin_count !== 4'd3 || gray_count !== 4'b0010) begin
      n_fail++;
      $display("FAIL pause_enter got paused=%b bin=%0d gray=%b want 1/3/0010", paused, bin_count, gray_count);
    end
    repeat (4) begin
      idle();
      n_checks++;
      if (bin_count !== 4'd3 || paused !== 1'b1) begin
        n_fail++; $display("FAIL pause_hold got bin=%0d paused=%b want 3/1", bin_count, paused);
      end
    end
    drive(0, 1, OP_RESUME, 4'd0, 0);
    n_checks++;
    if (paused !== 1'b0 || busy !== 1'b1 || bin_count !== 4'd3) begin
      n_fail++; $display("FAIL pause_resume got paused=%b busy=%b bin=%0d want 0/1/3", paused, busy, bin_count);
    end
    // Without the pause done follows edge T+1=8; six edges (PAUSE edge, four
    // held edges, RESUME edge) did not advance the count.
    edges = 9;
    while (done !== 1'b1 && edges < 40) begin
      idle();
      edges++;
    end
    n_checks++;
    if (edges != 14 || done !== 1'b1) begin
      n_fail++; $display("FAIL pause_delay got done edge %0d done=%b want edge 14 done=1", edges, done);
    end
    // PAUSE on the terminal edge suppresses the completion.
    drive(0, 1, OP_START, 4'd2, 0);
    repeat (2) idle();
    drive(0, 1, OP_PAUSE, 4'd0, 0);
    n_checks++;
    if (done !== 1'b0 || paused !== 1'b1 || bin_count !== 4'd2 || tally !== 8'd0) begin
      n_fail++; $display("FAIL pause_terminal got done=%b paused=%b bin=%0d tally=%0d want 0/1/2/0", done, paused, bin_count, tally);
    end
    drive(0, 1, OP_RESUME, 4'd0, 0);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || bin_count !== 4'd2) begin
      n_fail++; $display("FAIL pause_terminal_resume got done=%b busy=%b bin=%0d want 0/1/2", done, busy, bin_count);
    end
    idle();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bin_count !== 4'd2 || tally !== 8'd1) begin
      n_fail++; $display("FAIL pause_terminal_done got done=%b busy=%b bin=%0d tally=%0d want 1/0/2/1", done, busy, bin_count, tally);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] bad_ops [3];
    bad_ops[0] = OP_RESUME; bad_ops[1] = OP_STOP; bad_ops[2] = OP_PAUSE;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, bad_ops[i], 4'd9, 1);
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || bin_count !== 4'd2) begin
        n_fail++; $display("FAIL illegal_idle_op%0d got err=%b busy=%b bin=%0d want 1/0/2", bad_ops[i], err, busy, bin_count);
      end
    end
    idle();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse got err=%b want 0", err); end
    drive(0, 1, OP_START, 4'd6, 1);
    repeat (2) idle();
    drive(0, 1, OP_START, 4'd3, 0);
    n_checks++;
    if (err !== 1'b1 || bin_count !== 4'd3 || busy !== 1'b1) begin
      n_fail++; $display("FAIL illegal_start_run got err=%b bin=%0d busy=%b want 1/3/1", err, bin_count, busy);
    end
    idle();
    n_checks++;
    if (err !== 1'b0 || bin_count !== 4'd4) begin
      n_fail++; $display("FAIL illegal_after got err=%b bin=%0d want 0/4", err, bin_count);
    end
    repeat (3) idle();
    n_checks++;
    if (done !== 1'b1 || bin_count !== 4'd0 || busy !== 1'b1 || tally !== 8'd1) begin
      n_fail++; $display("FAIL illegal_target_kept got done=%b bin=%0d busy=%b tally=%0d want 1/0/1/1", done, bin_count, busy, tally);
    end
    drive(0, 1, OP_RESUME, 4'd0, 0);
    n_checks++;
    if (err !== 1'b1 || bin_count !== 4'd1 || tally !== 8'd1) begin
      n_fail++; $display("FAIL illegal_resume_run got err=%b bin=%0d tally=%0d want 1/1/1", err, bin_count, tally);
    end
    drive(0, 1, OP_STOP, 4'd0, 0);
  endtask

  task automatic test_abort();
    drive(0, 1, OP_START, 4'd7, 1);
    repeat (4) idle();
    drive(0, 1, OP_STOP, 4'd0, 0);
    n_checks++;
    if (bin_count !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_stop got bin=%0d busy=%b done=%b want 0/0/0", bin_count, busy, done);
    end
    idle();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got done=%b want 0", done); end
    drive(0, 1, OP_START, 4'd3, 1);
    repeat (4) idle();
    repeat (2) idle();
    n_checks++;
    if (tally !== 8'd1 || bin_count !== 4'd2) begin
      n_fail++; $display("FAIL abort_prerun got tally=%0d bin=%0d want 1/2", tally, bin_count);
    end
    drive(1, 1, OP_STOP, 4'd0, 0);
    n_checks++;
    if (busy !== 1'b0 || paused !== 1'b0 || bin_count !== 4'd0 || gray_count !== 4'd0 ||
        done !== 1'b0 || err !== 1'b0 || tally !== 8'd0) begin
      n_fail++; $display("FAIL abort_reset got busy=%b paused=%b bin=%0d gray=%h done=%b err=%b tally=%0d want all 0",
                         busy, paused, bin_count, gray_count, done, err, tally);
    end
    drive(0, 1, OP_START, 4'd2, 0);
    n_checks++;
    if (tally !== 8'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_restart got tally=%0d busy=%b want 0/1", tally, busy);
    end
    repeat (3) idle();
    n_checks++;
    if (done !== 1'b1 || tally !== 8'd1 || bin_count !== 4'd2 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_rerun got done=%b tally=%0d bin=%0d busy=%b want 1/1/2/0", done, tally, bin_count, busy);
    end
  endtask

  task automatic test_random();
    bit r, v, p;
    logic [1:0] op;
    logic [3:0] t;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 5) == 0);
      op = 2'($urandom_range(0, 3));
      t  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      p  = 1'($urandom_range(0, 1));
      drive(r, v, op, t, p);
      n_checks++;
      if (busy !== m_busy || paused !== m_paused || bin_count !== m_bin ||
          gray_count !== gray_tab[m_bin] || done !== m_done || err !== m_err ||
          tally !== 8'(m_tally)) begin
        n_fail++;
        $display("FAIL random_cyc%0d got busy=%b paused=%b bin=%0d gray=%h done=%b err=%b tally=%0d want %b/%b/%0d/%h/%b/%b/%0d",
                 i, busy, paused, bin_count, gray_count, done, err, tally,
                 m_busy, m_paused, m_bin, gray_tab[m_bin], m_done, m_err, m_tally);
      end
    end
  endtask

  initial begin
    build_gray_table();
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_illegal();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish before timeout");
    $fatal(1, "timeout");
  end

endmodule
